// File: rtl/ntt_psi_loader.sv
// Serial-to-parallel feeder for the radix-8 NTT butterfly: weights each coefficient by
// its slot's psi modulo Q and packs 8 of them into a ping-pong buffered bundle.
module ntt_psi_loader #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned Q     = 12289
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] psi_1,
    input  logic [WIDTH-1:0] psi_2,
    input  logic [WIDTH-1:0] psi_3,
    input  logic [WIDTH-1:0] psi_4,
    input  logic [WIDTH-1:0] psi_5,
    input  logic [WIDTH-1:0] psi_6,
    input  logic [WIDTH-1:0] psi_7,
    input  logic [WIDTH-1:0] psi_8,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output_1,
    output logic [WIDTH-1:0] output_2,
    output logic [WIDTH-1:0] output_3,
    output logic [WIDTH-1:0] output_4,
    output logic [WIDTH-1:0] output_5,
    output logic [WIDTH-1:0] output_6,
    output logic [WIDTH-1:0] output_7,
    output logic [WIDTH-1:0] output_8,
    output logic             drop_err
);

    function automatic logic [WIDTH-1:0] mod_q(input logic [2*WIDTH-1:0] p);
        logic [2*WIDTH-1:0] r;
        r = p % (2*WIDTH)'(Q);
        return r[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0]   bank [2][8];
    logic [1:0]         full;
    logic               wr_bank;
    logic               rd_bank;
    logic [2:0]         slot;

    logic [WIDTH-1:0]   psi_vec [8];
    logic               accept;
    logic               drain;
    logic [2:0]         wr_slot;
    logic [WIDTH-1:0]   psi_sel;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   weighted;

    assign psi_vec[0] = psi_1;
    assign psi_vec[1] = psi_2;
    assign psi_vec[2] = psi_3;
    assign psi_vec[3] = psi_4;
    assign psi_vec[4] = psi_5;
    assign psi_vec[5] = psi_6;
    assign psi_vec[6] = psi_7;
    assign psi_vec[7] = psi_8;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // A start-of-frame marker restarts the frame, so the coefficient lands in slot 0.
    assign wr_slot  = in_sof ? 3'd0 : slot;
    assign psi_sel  = psi_vec[wr_slot];
    assign product  = {{WIDTH{1'b0}}, in_data} * {{WIDTH{1'b0}}, psi_sel};
    assign weighted = mod_q(product);

    assign output_1 = bank[rd_bank][0];
    assign output_2 = bank[rd_bank][1];
    assign output_3 = bank[rd_bank][2];
    assign output_4 = bank[rd_bank][3];
    assign output_5 = bank[rd_bank][4];
    assign output_6 = bank[rd_bank][5];
    assign output_7 = bank[rd_bank][6];
    assign output_8 = bank[rd_bank][7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            slot     <= 3'd0;
            drop_err <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < 8; s++) begin
                    bank[b][s] <= '0;
                end
            end
        end else begin
            drop_err <= accept & in_sof & (slot != 3'd0);
            if (accept) begin
                bank[wr_bank][wr_slot] <= weighted;
                if (wr_slot == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    slot          <= 3'd0;
                end else begin
                    slot <= wr_slot + 3'd1;
                end
            end
            // A fill only targets a non-full bank and a drain only a full one, so they never collide.
            if (drain) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

endmodule
